// File: rtl/uart_bfm_8n1.sv
// Host-side 8N1 UART peer: independent transmitter and receiver sharing one clock.
// tx_start is a level request; tx_clear_req forces it low between frames so one held request sends one byte.
module uart_bfm_8n1 #(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       ser_tx,
    output logic       tx_busy,
    output logic       tx_clear_req,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic [1:0] recv_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_WAITLOW} tx_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3} rx_state_t;

    tx_state_t     tx_state, tx_state_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d;
    logic [2:0]    tx_bit, tx_bit_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic          ser_tx_d, tx_busy_d, tx_clear_d;

    rx_state_t     rx_state, rx_state_d;
    logic [CW-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]    rx_bit, rx_bit_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic [7:0]    rx_data_d;
    logic          rx_valid_d, rx_err_d;
    logic          rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            tx_state     <= T_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_shift     <= '0;
            ser_tx       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b0;
        end else begin
            tx_state     <= tx_state_d;
            tx_cnt       <= tx_cnt_d;
            tx_bit       <= tx_bit_d;
            tx_shift     <= tx_shift_d;
            ser_tx       <= ser_tx_d;
            tx_busy      <= tx_busy_d;
            tx_clear_req <= tx_clear_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        ser_tx_d   = ser_tx;
        tx_busy_d  = tx_busy;
        tx_clear_d = tx_clear_req;
        case (tx_state)
            T_IDLE: begin
                if (tx_start && !tx_clear_req) begin
                    tx_shift_d = tx_data;
                    tx_state_d = T_START;
                    ser_tx_d   = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            T_START: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = T_DATA;
                    ser_tx_d   = tx_shift[0];
                end else begin
                    tx_cnt_d = tx_cnt + CW'(1);
                end
            end
            T_DATA: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_d = T_STOP;
                        ser_tx_d   = 1'b1;
                    end else begin
                        // Shift right so the next bit is always at index 0.
                        tx_bit_d   = tx_bit + 3'd1;
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        ser_tx_d   = tx_shift[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CW'(1);
                end
            end
            T_STOP: begin
                if (tx_cnt == LAST) begin
                    tx_cnt_d  = '0;
                    tx_busy_d = 1'b0;
                    if (tx_start) begin
                        tx_state_d = T_WAITLOW;
                        tx_clear_d = 1'b1;
                    end else begin
                        tx_state_d = T_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CW'(1);
                end
            end
            T_WAITLOW: begin
                if (!tx_start) begin
                    tx_clear_d = 1'b0;
                    tx_state_d = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Synchronizer flops reset to the idle-high line level so release never looks like a start edge.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= R_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= ser_rx;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            rx_state     <= rx_state_d;
            rx_cnt       <= rx_cnt_d;
            rx_bit       <= rx_bit_d;
            rx_shift     <= rx_shift_d;
            rx_data      <= rx_data_d;
            rx_valid     <= rx_valid_d;
            rx_frame_err <= rx_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            R_START: begin
                if (rx_cnt == HALF) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s2 ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + CW'(1);
                end
            end
            R_DATA: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_bit_d = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + CW'(1);
                end
            end
            R_STOP: begin
                if (rx_cnt == LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    if (rx_s2) begin
                        rx_data_d  = rx_shift;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + CW'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    assign recv_state = rx_state;

endmodule

// File: tb/tb_uart_bfm_8n1.sv
// Directed and randomized bench for uart_bfm_8n1, with a bit-level frame model and loopback scoreboard.
module tb_uart_bfm_8n1;

    localparam int CLKS = 40;

    logic       clock;
    logic       resetb;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ser_tx;
    logic       tx_busy;
    logic       tx_clear_req;
    logic       ser_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic [1:0] recv_state;

    logic       loop_en;
    logic       rx_drive;

    int checks   = 0;
    int failures = 0;

    int valid_cnt = 0;
    int err_cnt   = 0;
    int start_cnt = 0;
    int data_cnt  = 0;
    logic [1:0] prev_state = 2'd0;
    logic [7:0] exp_q[$];

    assign ser_rx = loop_en ? ser_tx : rx_drive;

    uart_bfm_8n1 #(.CLKS_PER_BIT(CLKS)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ser_tx      (ser_tx),
        .tx_busy     (tx_busy),
        .tx_clear_req(tx_clear_req),
        .ser_rx      (ser_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .recv_state  (recv_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Receive-side monitor: scoreboard for rx_valid plus counts of pulses and state entries.
    always @(negedge clock) begin
        if (resetb) begin
            if (rx_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                else check("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
            end
            if (rx_frame_err) err_cnt++;
            if (recv_state == 2'd1 && prev_state != 2'd1) start_cnt++;
            if (recv_state == 2'd2 && prev_state != 2'd2) data_cnt++;
            prev_state = recv_state;
        end else begin
            prev_state = 2'd0;
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit hold);
        logic [9:0] frame;
        int t;
        int busy_cycles;
        bit saw_busy;
        frame = {1'b1, b, 1'b0};
        @(negedge clock);
        tx_data  = b;
        tx_start = 1'b1;
        check("busy_pre", 32'(tx_busy), 32'd0);
        @(negedge clock);
        check("busy_rise", 32'(tx_busy), 32'd1);
        if (!hold) tx_start = 1'b0;
        tx_data = 8'($urandom_range(0, 255));
        busy_cycles = 0;
        t = 0;
        while (tx_busy && t < 12 * CLKS) begin
            if ((t % CLKS) == CLKS / 2 && (t / CLKS) < 10)
                check("tx_bit", 32'(ser_tx), 32'(frame[t / CLKS]));
            busy_cycles++;
            t++;
            @(negedge clock);
        end
        check("busy_len", 32'(busy_cycles), 32'(10 * CLKS));
        check("ser_idle", 32'(ser_tx), 32'd1);
        if (hold) begin
            check("clear_req_set", 32'(tx_clear_req), 32'd1);
            saw_busy = 1'b0;
            repeat (3 * CLKS) begin
                @(negedge clock);
                if (tx_busy || !ser_tx) saw_busy = 1'b1;
            end
            check("one_frame", 32'(saw_busy), 32'd0);
            tx_start = 1'b0;
            @(negedge clock);
            check("clear_req_drop", 32'(tx_clear_req), 32'd0);
        end else begin
            check("clear_req_idle", 32'(tx_clear_req), 32'd0);
        end
    endtask

    initial begin
        int v0, e0, s0, d0;
        logic [7:0] last_byte;
        logic [7:0] b;
        logic [9:0] bad;
        bit idle_bad;

        resetb   = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        last_byte = 8'h00;

        repeat (3) @(negedge clock);
        check("rst_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_clear", 32'(tx_clear_req), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_err", 32'(rx_frame_err), 32'd0);
        check("rst_state", 32'(recv_state), 32'd0);

        resetb = 1'b1;
        idle_bad = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (!ser_tx || tx_busy || tx_clear_req || rx_valid || rx_frame_err || recv_state != 2'd0)
                idle_bad = 1'b1;
        end
        check("idle_quiet", 32'(idle_bad), 32'd0);

        // Single frame with tx_start held high through the whole frame.
        send_frame(8'h01, 1'b1);
        check("no_rx_when_unlooped", 32'(valid_cnt), 32'd0);

        // Loopback: 0x01..0x20 in order, then random bytes.
        loop_en = 1'b1;
        s0 = start_cnt;
        for (int i = 1; i <= 32; i++) begin
            b = 8'(i);
            exp_q.push_back(b);
            send_frame(b, 1'b0);
            last_byte = b;
        end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b0);
            last_byte = b;
        end
        repeat (2 * CLKS) @(negedge clock);
        check("loop_valid_cnt", 32'(valid_cnt), 32'd40);
        check("loop_start_cnt", 32'(start_cnt - s0), 32'd40);
        check("loop_q_empty", 32'(exp_q.size()), 32'd0);
        check("loop_no_err", 32'(err_cnt), 32'd0);
        check("loop_rx_last", 32'(rx_data), 32'(last_byte));

        // Short low pulse on the line is rejected at the mid-start re-sample.
        loop_en = 1'b0;
        v0 = valid_cnt; e0 = err_cnt; s0 = start_cnt; d0 = data_cnt;
        @(negedge clock);
        rx_drive = 1'b0;
        repeat (CLKS / 4) @(negedge clock);
        rx_drive = 1'b1;
        repeat (3 * CLKS) @(negedge clock);
        check("glitch_start", 32'(start_cnt - s0), 32'd1);
        check("glitch_no_data", 32'(data_cnt - d0), 32'd0);
        check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_no_err", 32'(err_cnt - e0), 32'd0);
        check("glitch_idle", 32'(recv_state), 32'd0);

        // 0xA5 with a low stop bit.
        v0 = valid_cnt; e0 = err_cnt;
        bad = {1'b0, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drive = bad[k];
            repeat (CLKS) @(negedge clock);
        end
        rx_drive = 1'b1;
        repeat (2 * CLKS) @(negedge clock);
        check("ferr_pulse", 32'(err_cnt - e0), 32'd1);
        check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr_data_kept", 32'(rx_data), 32'(last_byte));

        // Reset in the middle of frame bit 4, then a clean 0x3C frame.
        @(negedge clock);
        tx_data  = 8'($urandom_range(0, 255));
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (4 * CLKS + CLKS / 2) @(negedge clock);
        check("mid_frame_busy", 32'(tx_busy), 32'd1);
        resetb = 1'b0;
        @(negedge clock);
        check("abort_ser_tx", 32'(ser_tx), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_state", 32'(recv_state), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'd0);
        resetb = 1'b1;
        @(negedge clock);
        loop_en = 1'b1;
        v0 = valid_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0);
        repeat (2 * CLKS) @(negedge clock);
        check("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
        check("post_rst_rx", 32'(rx_data), 32'h3C);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
